branch_sequencer: RTL

//   Multi-cycle control sequencer for conditional branches (brzr/brnz/brpl/brmi).

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/branch_sequencer_sat_counter.sv | 32 +++
 rtl/branch_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding, ALU opcodes,
// branch condition codes and the strobe bundle driven towards the datapath.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_PCY    = 3'd2,
        S_ADD    = 3'd3,
        S_COMMIT = 3'd4
    } state_e;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd3;

    typedef enum logic [1:0] {
        C2_ZR = 2'b00,
        C2_NZ = 2'b01,
        C2_PL = 2'b10,
        C2_MI = 2'b11
    } c2_e;

    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic busy;
        logic done;
    } strobes_t;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: flops update with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// Five-step control sequencer for conditional branches: evaluates R[Ra] into the
// CON FF, forms PC+C through Y/Z, and loads PC only when the sampled CON_out is set.
module branch_sequencer #(
    parameter int unsigned C2_LSB  = 19,
    parameter int unsigned RA_LSB  = 23,
    parameter logic [4:0]  ALU_ADD = 5'd3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             con_out,
    output logic [1:0]       IR_bits,
    output logic [3:0]       ra_sel,
    output logic             gra,
    output logic             r_out,
    output logic             CON_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic [4:0]       alu_op,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    import cpu_ctrl_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] ir_bits_q, ir_bits_d;
    logic [3:0] ra_sel_q, ra_sel_d;
    logic       taken_q, taken_d;
    logic       accept;
    logic       commit;
    strobes_t   strb;
    logic       unused_ir;

    // Only the condition and Ra fields matter; the rest of IR belongs to other units.
    assign unused_ir = ^ir;

    assign accept = (state_q == S_IDLE) && start;
    assign commit = (state_q == S_COMMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ir_bits_q <= '0;
            ra_sel_q  <= '0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_bits_q <= ir_bits_d;
            ra_sel_q  <= ra_sel_d;
            taken_q   <= taken_d;
        end
    end

    // A new branch is only taken from idle; any other encoding falls back to idle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = start ? S_EVAL : S_IDLE;
            S_EVAL:   state_d = S_PCY;
            S_PCY:    state_d = S_ADD;
            S_ADD:    state_d = S_COMMIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_bits_d = ir_bits_q;
        ra_sel_d  = ra_sel_q;
        taken_d   = taken_q;
        if (accept) begin
            ir_bits_d = ir[C2_LSB +: 2];
            ra_sel_d  = ir[RA_LSB +: 4];
        end
        if (commit) begin
            taken_d = con_out;
        end
    end

    always_comb begin
        strb   = '0;
        alu_op = ALU_NOP;
        case (state_q)
            S_EVAL: begin
                strb.gra    = 1'b1;
                strb.r_out  = 1'b1;
                strb.con_in = 1'b1;
                strb.busy   = 1'b1;
            end
            S_PCY: begin
                strb.pc_out = 1'b1;
                strb.y_in   = 1'b1;
                strb.busy   = 1'b1;
            end
            S_ADD: begin
                strb.c_out = 1'b1;
                strb.z_in  = 1'b1;
                strb.busy  = 1'b1;
                alu_op     = ALU_ADD;
            end
            S_COMMIT: begin
                // con_out is a flop output, so it is stable for the whole commit cycle.
                strb.zlo_out = con_out;
                strb.pc_in   = con_out;
                strb.busy    = 1'b1;
                strb.done    = 1'b1;
            end
            default: strb = '0;
        endcase
    end

    assign gra     = strb.gra;
    assign r_out   = strb.r_out;
    assign CON_in  = strb.con_in;
    assign pc_out  = strb.pc_out;
    assign y_in    = strb.y_in;
    assign c_out   = strb.c_out;
    assign z_in    = strb.z_in;
    assign zlo_out = strb.zlo_out;
    assign pc_in   = strb.pc_in;
    assign busy    = strb.busy;
    assign done    = strb.done;
    assign IR_bits = ir_bits_q;
    assign ra_sel  = ra_sel_q;
    assign taken   = taken_q;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (commit && con_out),
        .count   (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ntaken_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (commit && !con_out),
        .count   (ntaken_cnt)
    );

endmodule
